// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: N-to-1 round-robin arbiter for valid/ready streams.
// A grant is held for one packet (ended by last) or MAX_BURST beats, whichever
// comes first; priority then rotates to the requester after the one just served.
// The data path is purely combinational; only the arbitration state is registered.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_valid_in   [N]     per-requester valid
//   i_data_in    [N*L]   requester i data at [i*L +: L]
//   i_last_in    [N]     per-requester end-of-packet (qualified by valid)
//   o_ready_in   [N]     per-requester ready, at most one bit high
//   o_valid_out          downstream valid
//   o_data_out   [L]     downstream data
//   o_last_out           downstream last
//   i_ready_out          downstream ready
//   o_grant      [N]     one-hot current owner, 0 when none
//   o_busy               high while a grant is locked
module rr_stream_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned L         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_valid_in,
  input  logic [N*L-1:0] i_data_in,
  input  logic [N-1:0]   i_last_in,
  output logic [N-1:0]   o_ready_in,
  output logic           o_valid_out,
  output logic [L-1:0]   o_data_out,
  output logic           o_last_out,
  input  logic           i_ready_out,
  output logic [N-1:0]   o_grant,
  output logic           o_busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          r_state, w_state_d;
  logic [PW-1:0]   r_ptr, w_ptr_d;
  logic [PW-1:0]   r_owner, w_owner_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;

  logic [PW-1:0]   w_cand;
  logic [PW-1:0]   w_win;
  logic            w_found;
  logic [PW-1:0]   w_sel;
  logic            w_sel_vld;
  logic [N-1:0]    w_onehot;
  logic            w_hs;
  logic            w_term;

  // Modulo-N increment without a divider; also handles non-power-of-two N.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] a);
    return (a == PW'(N - 1)) ? '0 : a + PW'(1);
  endfunction

  // Round-robin search starting at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = r_ptr;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && i_valid_in[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  // Selected source: locked owner, or this cycle's winner while idle.
  always_comb begin
    w_sel     = (r_state == StLocked) ? r_owner : w_win;
    w_sel_vld = (r_state == StLocked) || w_found;
    w_onehot  = '0;
    if (w_sel_vld) begin
      w_onehot[w_sel] = 1'b1;
    end
  end

  always_comb begin
    o_valid_out = 1'b0;
    o_data_out  = '0;
    o_last_out  = 1'b0;
    if (w_sel_vld) begin
      o_valid_out = i_valid_in[w_sel];
      o_data_out  = i_data_in[w_sel * L +: L];
      o_last_out  = i_last_in[w_sel];
    end
  end

  // ready_out reaches ready_in only through this AND; valid_out never depends on it.
  assign o_ready_in = w_onehot & {N{i_ready_out}};
  assign o_grant    = w_onehot;
  assign o_busy     = (r_state == StLocked);

  assign w_hs   = o_valid_out & i_ready_out;
  assign w_term = w_hs & (o_last_out | (r_cnt == CW'(MAX_BURST - 1)));

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_owner_d = r_owner;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          if (w_term) begin
            // Single-beat grant completes without ever locking.
            w_ptr_d = wrap_inc(w_win);
            w_cnt_d = '0;
          end else begin
            // Lock on a stall too, so the grant stays put while valid is held.
            w_owner_d = w_win;
            w_cnt_d   = w_hs ? CW'(1) : '0;
            w_state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (w_term) begin
          w_ptr_d   = wrap_inc(r_owner);
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else if (w_hs) begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_owner <= w_owner_d;
      r_cnt   <= w_cnt_d;
    end
  end

endmodule
